// File: rtl/disp_pkg.sv
// Shared definitions for the display VRAM read controller: FSM states,
// default burst geometry and the AXI OKAY response code.
package disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAITVS = 3'd1,
    ST_HOLD   = 3'd2,
    ST_ARREQ  = 3'd3,
    ST_DATA   = 3'd4
  } disp_state_e;

  localparam int unsigned DEF_BURST_LEN    = 16;
  localparam int unsigned DEF_BUS_BYTES    = 8;
  localparam int unsigned DEF_FRAME_BURSTS = 9600;

  localparam logic [1:0] RRESP_OKAY = 2'b00;

endpackage

// File: rtl/disp_vsync_edge.sv
// Brings the active-low VSYNC into the ACLK domain and emits a one-cycle
// frame-start pulse on each synchronized falling edge.
module disp_vsync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vsync_x_i,
  output logic frame_start_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-flop synchronizer plus history flop; all reset high (VSYNC inactive)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= vsync_x_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign frame_start_o = prev_q & ~sync_q;

endmodule

// File: rtl/disp_vramctrl.sv
// Display VRAM read controller: one AXI read burst at a time per frame.
// Optional RRESP error flag enabled by defining DISP_RRESP_CHECK_EN.
module disp_vramctrl
  import disp_pkg::*;
#(
  parameter int unsigned BURST_LEN    = DEF_BURST_LEN,
  parameter int unsigned BUS_BYTES    = DEF_BUS_BYTES,
  parameter int unsigned FRAME_BURSTS = DEF_FRAME_BURSTS
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        DSP_VSYNC_X,
  input  logic        DISPON,
  input  logic [31:0] DISPADDR,
  input  logic        FIFO_ROOM,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic        RVALID,
  input  logic        RLAST,
  input  logic [1:0]  RRESP,
  output logic        RREADY,
  output logic        FIFO_WR,
  output logic        RD_ERR
);

  localparam int unsigned CNT_W     = $clog2(FRAME_BURSTS + 1);
  localparam logic [31:0] ADDR_STEP = 32'(BURST_LEN * BUS_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BURSTS);

  disp_state_e      state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_start_s;
  logic             latch_s;

  disp_vsync_edge u_vsync_edge (
    .clk_i         (ACLK),
    .rst_i         (ARST),
    .vsync_x_i     (DSP_VSYNC_X),
    .frame_start_o (frame_start_s)
  );

  // State, address and burst-count registers
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0000_0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a frame start outside WAITVS is deliberately ignored
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    latch_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (DISPON) state_d = ST_WAITVS;
        else        state_d = ST_IDLE;
      end
      ST_WAITVS: begin
        if (frame_start_s && DISPON) begin
          state_d = ST_HOLD;
          addr_d  = DISPADDR;
          cnt_d   = '0;
          latch_s = 1'b1;
        end else if (!DISPON && !frame_start_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAITVS;
        end
      end
      ST_HOLD: begin
        if (!DISPON)        state_d = ST_WAITVS;
        else if (FIFO_ROOM) state_d = ST_ARREQ;
        else                state_d = ST_HOLD;
      end
      ST_ARREQ: begin
        if (ARREADY) begin
          state_d = ST_DATA;
          addr_d  = addr_q + ADDR_STEP;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_ARREQ;
        end
      end
      ST_DATA: begin
        if (RVALID && RLAST) begin
          if ((cnt_q == CNT_LAST) || !DISPON) state_d = ST_WAITVS;
          else                                state_d = ST_HOLD;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ARADDR  = addr_q;
  assign ARLEN   = 8'(BURST_LEN - 1);
  assign ARVALID = (state_q == ST_ARREQ);
  assign RREADY  = (state_q == ST_DATA);
  assign FIFO_WR = RVALID & RREADY;

`ifdef DISP_RRESP_CHECK_EN
  logic rd_err_q, rd_err_d;

  // Sticky error: cleared by a new frame latch, set by any non-OKAY beat
  always_comb begin
    if (latch_s)                              rd_err_d = 1'b0;
    else if (FIFO_WR && (RRESP != RRESP_OKAY)) rd_err_d = 1'b1;
    else                                      rd_err_d = rd_err_q;
  end

  // Error flag register
  always_ff @(posedge ACLK) begin
    if (ARST) rd_err_q <= 1'b0;
    else      rd_err_q <= rd_err_d;
  end

  assign RD_ERR = rd_err_q;
`else
  logic unused_rresp_s;
  assign unused_rresp_s = ^{RRESP, latch_s};
  assign RD_ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_disp_vramctrl.sv
// Directed self-checking bench for disp_vramctrl (default parameters).
module tb_disp_vramctrl;
  import disp_pkg::*;

`ifdef DISP_RRESP_CHECK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  logic        ACLK = 1'b0;
  logic        ARST, DSP_VSYNC_X, DISPON, FIFO_ROOM;
  logic [31:0] DISPADDR, ARADDR;
  logic [7:0]  ARLEN;
  logic        ARVALID, ARREADY, RVALID, RLAST, RREADY, FIFO_WR, RD_ERR;
  logic [1:0]  RRESP;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] addr_log[$];
  int hs0, wr0;

  disp_vramctrl dut (
    .ACLK(ACLK), .ARST(ARST), .DSP_VSYNC_X(DSP_VSYNC_X), .DISPON(DISPON),
    .DISPADDR(DISPADDR), .FIFO_ROOM(FIFO_ROOM), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RVALID(RVALID), .RLAST(RLAST),
    .RRESP(RRESP), .RREADY(RREADY), .FIFO_WR(FIFO_WR), .RD_ERR(RD_ERR)
  );

  always #5 ACLK = ~ACLK;

  // Handshake / write monitor sampled at the active edge
  always @(posedge ACLK) begin
    if (ARVALID && ARREADY) begin
      addr_log.push_back(ARADDR);
      hs_cnt = hs_cnt + 1;
    end
    if (FIFO_WR) wr_cnt = wr_cnt + 1;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic vsync_fall();
    DSP_VSYNC_X = 1'b0;
    tick();
    tick();
    DSP_VSYNC_X = 1'b1;
  endtask

  task automatic wait_state(input disp_state_e tgt, input int budget, input string tag);
    int n = 0;
    while ((dut.state_q != tgt) && (n < budget)) begin
      tick();
      n++;
    end
    chk(tag, 32'(dut.state_q), 32'(tgt));
  endtask

  initial begin
    ARST = 1'b1; DSP_VSYNC_X = 1'b1; DISPON = 1'b0; DISPADDR = 32'h0;
    FIFO_ROOM = 1'b0; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    tick(); tick(); tick();
    chk("rst_state",   32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_arvalid", 32'(ARVALID), 32'd0);
    chk("rst_rready",  32'(RREADY), 32'd0);
    chk("rst_fifo_wr", 32'(FIFO_WR), 32'd0);
    chk("rst_araddr",  ARADDR, 32'h0000_0000);
    chk("rst_rd_err",  32'(RD_ERR), 32'd0);
    chk("arlen",       32'(ARLEN), 32'd15);

    // Full frame; responder ends each burst on its first beat to keep the run short
    DISPON = 1'b1; DISPADDR = 32'h2000_0000; FIFO_ROOM = 1'b1;
    ARREADY = 1'b1; RVALID = 1'b1; RLAST = 1'b1;
    ARST = 1'b0;
    hs0 = hs_cnt;
    tick();
    chk("idle_to_waitvs", 32'(dut.state_q), 32'(ST_WAITVS));
    vsync_fall();
    wait_state(ST_HOLD, 10, "frame_start_hold");
    wait_state(ST_WAITVS, 40000, "frame_end_waitvs");
    chk("frame_handshakes", 32'(hs_cnt - hs0), 32'd9600);
    chk("first_araddr",  addr_log[hs0],        32'h2000_0000);
    chk("second_araddr", addr_log[hs0 + 1],    32'h2000_0080);
    chk("last_araddr",   addr_log[hs0 + 9599], 32'h2012_BF80);
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    tick();
    chk("frame_end_stays", 32'(dut.state_q), 32'(ST_WAITVS));
    chk("waitvs_rready",   32'(RREADY), 32'd0);

    // FIFO back-pressure, ARREADY stall, DISPADDR change after latch, error beat
    FIFO_ROOM = 1'b0; DISPADDR = 32'h1000_0000;
    vsync_fall();
    wait_state(ST_HOLD, 10, "hold_entry");
    DISPADDR = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_no_arvalid", 32'(ARVALID), 32'd0);
    end
    FIFO_ROOM = 1'b1;
    hs0 = hs_cnt;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stall_arvalid", 32'(ARVALID), 32'd1);
      chk("stall_araddr",  ARADDR, 32'h1000_0000);
    end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    chk("stall_one_hs", 32'(hs_cnt - hs0), 32'd1);
    chk("data_rready",  32'(RREADY), 32'd1);
    chk("addr_advance", ARADDR, 32'h1000_0080);
    wr0 = wr_cnt;
    for (int i = 1; i <= 16; i++) begin
      RVALID = 1'b1;
      RLAST  = (i == 16);
      RRESP  = (i == 2) ? 2'b10 : 2'b00;
      if (i == 16) FIFO_ROOM = 1'b0;
      #1;
      if (i == 1) chk("fifo_wr_zero_lat", 32'(FIFO_WR), 32'd1);
      tick();
    end
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    chk("burst_wr_count", 32'(wr_cnt - wr0), 32'd16);
    chk("after_burst_hold", 32'(dut.state_q), 32'(ST_HOLD));
    chk("rd_err_set", 32'(RD_ERR), EXP_ERR);
    tick();
    chk("room0_no_arvalid", 32'(ARVALID), 32'd0);
    FIFO_ROOM = 1'b1;
    tick();
    chk("room1_arvalid", 32'(ARVALID), 32'd1);
    chk("room1_araddr",  ARADDR, 32'h1000_0080);

    // DISPON dropped during beat 3: burst finishes, then WAITVS and IDLE
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    wr0 = wr_cnt;
    for (int i = 1; i <= 16; i++) begin
      RVALID = 1'b1;
      RLAST  = (i == 16);
      if (i == 3) DISPON = 1'b0;
      tick();
    end
    RVALID = 1'b0; RLAST = 1'b0;
    chk("dispoff_wr_count", 32'(wr_cnt - wr0), 32'd16);
    chk("dispoff_waitvs",   32'(dut.state_q), 32'(ST_WAITVS));
    hs0 = hs_cnt;
    tick();
    chk("dispoff_idle", 32'(dut.state_q), 32'(ST_IDLE));
    tick(); tick();
    chk("dispoff_no_hs",   32'(hs_cnt - hs0), 32'd0);
    chk("dispoff_arvalid", 32'(ARVALID), 32'd0);
    chk("rd_err_sticky",   32'(RD_ERR), EXP_ERR);

    // Error clears on new frame; reset in ARREQ; restart at new address
    DISPON = 1'b1; DISPADDR = 32'h3000_0000;
    tick();
    vsync_fall();
    wait_state(ST_HOLD, 10, "frame2_hold");
    chk("rd_err_cleared", 32'(RD_ERR), 32'd0);
    tick();
    chk("frame2_arvalid", 32'(ARVALID), 32'd1);
    chk("frame2_araddr",  ARADDR, 32'h3000_0000);
    ARST = 1'b1;
    tick();
    chk("rst_mid_arvalid", 32'(ARVALID), 32'd0);
    chk("rst_mid_state",   32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_mid_araddr",  ARADDR, 32'h0000_0000);
    ARST = 1'b0; DISPADDR = 32'h4000_0100;
    tick();
    vsync_fall();
    wait_state(ST_HOLD, 10, "frame3_hold");
    tick();
    chk("frame3_araddr", ARADDR, 32'h4000_0100);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    chk("frame3_next_addr", ARADDR, 32'h4000_0180);

    // 32-bit address wrap
    ARST = 1'b1;
    tick();
    ARST = 1'b0; DISPADDR = 32'hFFFF_FFC0;
    tick();
    vsync_fall();
    wait_state(ST_HOLD, 10, "wrap_hold");
    tick();
    chk("wrap_first", ARADDR, 32'hFFFF_FFC0);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    chk("wrap_next", ARADDR, 32'h0000_0040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_vramctrl.md
DISP_VRAMCTRL -- requirements
Module: disp_vramctrl

Interface
REQ-001 Parameters: BURST_LEN, default 16, AXI beats per burst; BUS_BYTES, default 8, bytes per beat; FRAME_BURSTS, default 9600, bursts per frame (640x480x4 B / 128 B).
REQ-002 Ports: ACLK, input, 1, single clock; all logic SHALL be clocked on its rising edge.
REQ-003 ARST, input, 1, synchronous active-high reset.
REQ-004 DSP_VSYNC_X, input, 1, active-low vertical sync from the display timing block (asynchronous to ACLK).
REQ-005 DISPON, input, 1, display enable from the register block; DISPADDR, input, 32, frame base address.
REQ-006 FIFO_ROOM, input, 1, the pixel FIFO can accept one full burst.
REQ-007 ARADDR, output, 32; ARLEN, output, 8, constant BURST_LEN-1; ARVALID, output, 1; ARREADY, input, 1.
REQ-008 RVALID, input, 1; RLAST, input, 1; RRESP, input, 2; RREADY, output, 1.
REQ-009 FIFO_WR, output, 1, pixel FIFO write strobe; RD_ERR, output, 1, sticky read-error flag.

Function
REQ-010 FSM states: IDLE, WAITVS, HOLD, ARREQ, DATA.
REQ-011 IDLE→WAITVS when DISPON=1; WAITVS→IDLE when DISPON=0 and no frame-start pulse is present.
REQ-012 The frame-start pulse is a one-cycle pulse on each synchronized falling edge of DSP_VSYNC_X.
REQ-013 WAITVS→HOLD on the frame-start pulse with DISPON=1; on that cycle latch DISPADDR into the address register and clear the burst counter.
REQ-014 HOLD→ARREQ when FIFO_ROOM=1; ARVALID=1 exactly while in ARREQ, with ARADDR driven from the address register.
REQ-015 In ARREQ, ARVALID and ARADDR SHALL hold stable until ARREADY=1; on the ARREADY cycle, add BURST_LEN*BUS_BYTES to the address, increment the burst counter, and go to DATA.
REQ-016 At most one burst SHALL be outstanding.
REQ-017 RREADY=1 only in DATA; FIFO_WR = RVALID & RREADY, the same cycle, with zero latency.
REQ-018 On RVALID & RLAST in DATA: go to WAITVS if the burst counter equals FRAME_BURSTS or DISPON=0, else to HOLD.
REQ-019 DISPON falling mid-frame: the burst in flight completes (the ARREQ handshake and all its beats), then the FSM goes to WAITVS and then IDLE; no new ARVALID is issued.
REQ-020 Frame-start pulse in HOLD, ARREQ or DATA: ignored; the current frame continues.
REQ-021 Address arithmetic is 32-bit modulo 2^32; wrap-around is permitted and not flagged.
REQ-022 DISPADDR changes after the latch cycle SHALL NOT affect the current frame.

Reset
REQ-023 On ARST: state=IDLE, ARVALID=0, RREADY=0, FIFO_WR=0, ARADDR=0, burst counter=0, RD_ERR=0, synchronizer flops=1 (VSYNC inactive).
REQ-024 Reset mid-operation takes priority over every transition and drops ARVALID and RREADY on the next edge.

Configuration
REQ-025 With DISP_RRESP_CHECK_EN defined: RD_ERR sets on any accepted beat with RRESP!=2'b00 and clears only on ARST or on a frame-start latch.
REQ-026 Without DISP_RRESP_CHECK_EN: RD_ERR is tied to 0, RRESP is ignored, and no error logic is synthesized.

Structure
REQ-027 Package disp_pkg SHALL hold the FSM state enum, the default BURST_LEN, BUS_BYTES and FRAME_BURSTS values, and the RRESP OKAY constant.
REQ-028 Sub-module disp_vsync_edge SHALL contain the two-flop synchronizer and falling-edge detector, and output the one-cycle frame-start pulse.

Verification
REQ-029 DISPON=1, DISPADDR=0x2000_0000, VSYNC falling edge, FIFO_ROOM=1, ARREADY always 1 → first ARADDR=0x2000_0000, second ARADDR=0x2000_0080; exactly 9600 ARVALID handshakes, then WAITVS.
REQ-030 ARREADY held low for 5 cycles in ARREQ → ARVALID and ARADDR stable for all 6 cycles; one handshake only.
REQ-031 FIFO_ROOM=0 after a burst → ARVALID stays 0 in HOLD; FIFO_ROOM=1 → ARVALID on the next cycle.
REQ-032 DISPON cleared during beat 3 of a burst → the remaining 13 beats produce FIFO_WR, then no further ARVALID; state IDLE.
REQ-033 Beat with RRESP=2'b10 → RD_ERR=1 when DISP_RRESP_CHECK_EN is defined, 0 without it; RD_ERR clears at the next frame start.
REQ-034 ARST asserted in ARREQ → ARVALID=0 and state IDLE on the next edge; the next frame restarts at the newly latched DISPADDR.
